// File: rtl/noise_pkg.sv
// Shared widths, filter shift and output-state encoding for the noise sample shaper.
package noise_pkg;

  localparam int NOISE_DW        = 12;
  localparam int NOISE_DIV_W     = 16;
  localparam int NOISE_GAIN_W    = 8;
  localparam int NOISE_LPF_SHIFT = 2;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/noise_rate_div.sv
// Sample-rate divider: counts 0..i_div while enabled and ticks on the wrap cycle.
module noise_rate_div #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  assign o_tick = i_en && (count_q == i_div);

  always_comb begin
    count_d = count_q + {{(DIV_W-1){1'b0}}, 1'b1};
    if (!i_en || o_tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/noise_sample_shaper.sv
// Samples a random word at a programmable rate, scales it by (gain+1)/256 and hands it
// downstream through a one-entry output register. Define NOISE_LPF_EN to add a one-pole low-pass.
module noise_sample_shaper
  import noise_pkg::*;
#(
  parameter int DW    = NOISE_DW,
  parameter int DIV_W = NOISE_DIV_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [DW-1:0]           i_rnd,
  input  logic                    i_en,
  input  logic [DIV_W-1:0]        i_div,
  input  logic [NOISE_GAIN_W-1:0] i_gain,
  input  logic                    i_ready,
  input  logic                    i_clr_ovf,
  output logic [DW-1:0]           o_data,
  output logic                    o_valid,
  output logic                    o_ovf
);

  logic tick;

  noise_rate_div #(.DIV_W(DIV_W)) u_rate_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_div  (i_div),
    .o_tick (tick)
  );

  logic [DW-1:0] s1_q;
  logic          s1_vld_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= tick;
      if (tick) begin
        s1_q <= i_rnd;
      end
    end
  end

  // Gain is read here, in the cycle the sample leaves S1, not when it was captured.
  logic [NOISE_GAIN_W:0]       gain_p1;
  logic [DW+NOISE_GAIN_W:0]    prod;
  logic [DW-1:0]               scaled;

  assign gain_p1 = {1'b0, i_gain} + {{NOISE_GAIN_W{1'b0}}, 1'b1};
  assign prod    = {{(NOISE_GAIN_W+1){1'b0}}, s1_q} * {{DW{1'b0}}, gain_p1};
  assign scaled  = DW'(prod >> NOISE_GAIN_W);

  logic [DW-1:0] res_data;
  logic          res_vld;

`ifdef NOISE_LPF_EN
  logic signed [DW+1:0] y_q;
  logic signed [DW+1:0] y_d;
  logic signed [DW+1:0] diff;
  logic                 y_vld_q;

  assign diff = signed'({2'b00, scaled}) - y_q;
  assign y_d  = y_q + (diff >>> NOISE_LPF_SHIFT);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      y_q     <= '0;
      y_vld_q <= 1'b0;
    end else begin
      y_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        y_q <= y_d;
      end
    end
  end

  always_comb begin
    res_data = y_q[DW-1:0];
    if (y_q[DW+1]) begin
      res_data = '0;
    end else if (y_q[DW]) begin
      res_data = '1;
    end
  end
  assign res_vld = y_vld_q;
`else
  assign res_data = scaled;
  assign res_vld  = s1_vld_q;
`endif

  out_state_e    state_q;
  logic [DW-1:0] data_q;
  logic          ovf_q;
  logic          drop;

  // A result that finds the register full and not being drained is lost.
  assign drop = res_vld && (state_q == OUT_FULL) && !i_ready;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (i_clr_ovf) begin
        ovf_q <= 1'b0;
      end
      if (state_q == OUT_EMPTY) begin
        if (res_vld) begin
          state_q <= OUT_FULL;
          data_q  <= res_data;
        end
      end else if (i_ready) begin
        if (res_vld) begin
          data_q <= res_data;
        end else begin
          state_q <= OUT_EMPTY;
        end
      end
    end
  end

  assign o_data  = data_q;
  assign o_valid = (state_q == OUT_FULL);
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_noise_sample_shaper.sv
// Directed self-checking bench for noise_sample_shaper; expectations follow NOISE_LPF_EN.
module tb_noise_sample_shaper;

`ifdef NOISE_LPF_EN
  localparam int LAT = 3;
  localparam logic [11:0] FIRST_ACE = 12'h2B3;
`else
  localparam int LAT = 2;
  localparam logic [11:0] FIRST_ACE = 12'hACE;
`endif

  logic        clk = 1'b0;
  logic        i_rst;
  logic [11:0] i_rnd;
  logic        i_en;
  logic [15:0] i_div;
  logic [7:0]  i_gain;
  logic        i_ready;
  logic        i_clr_ovf;
  logic [11:0] o_data;
  logic        o_valid;
  logic        o_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noise_sample_shaper dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_rnd     (i_rnd),
    .i_en      (i_en),
    .i_div     (i_div),
    .i_gain    (i_gain),
    .i_ready   (i_ready),
    .i_clr_ovf (i_clr_ovf),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_ovf     (o_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst     = 1'b0;
    i_en      = 1'b0;
    i_clr_ovf = 1'b0;
    repeat (2) step();
    i_rst = 1'b1;
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_en = 1'b1; i_div = 16'd0; i_rnd = 12'hACE;
    i_gain = 8'd255; i_ready = 1'b0; i_clr_ovf = 1'b0;
    repeat (3) step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_data !== 12'h000) begin errors++; $display("FAIL reset_data got %h want 000", o_data); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", o_ovf); end
    $display("test_reset done");
  endtask

  task automatic test_rate();
    logic exp_v;
    do_reset();
    i_div = 16'd3; i_ready = 1'b1; i_rnd = 12'hACE; i_gain = 8'd255; i_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_v = (k >= 3 + LAT) && (((k - 3 - LAT) % 4) == 0);
      checks++;
      if (o_valid !== exp_v) begin errors++; $display("FAIL rate_valid edge %0d got %b want %b", k, o_valid, exp_v); end
`ifndef NOISE_LPF_EN
      if (exp_v) begin
        checks++;
        if (o_data !== 12'hACE) begin errors++; $display("FAIL rate_data edge %0d got %h want ace", k, o_data); end
      end
`endif
    end
    i_en = 1'b0;
    repeat (LAT + 2) step();
    $display("test_rate done");
  endtask

  task automatic test_gain();
`ifndef NOISE_LPF_EN
    logic [7:0]  gains [3];
    logic [11:0] wants [3];
    gains[0] = 8'd255; wants[0] = 12'hACE;
    gains[1] = 8'd127; wants[1] = 12'h567;
    gains[2] = 8'd0;   wants[2] = 12'h00A;
    do_reset();
    i_div = 16'd0; i_ready = 1'b1; i_rnd = 12'hACE; i_en = 1'b1;
    for (int g = 0; g < 3; g++) begin
      i_gain = gains[g];
      repeat (3) step();
      checks++;
      if (o_data !== wants[g]) begin errors++; $display("FAIL gain_%0d got %h want %h", gains[g], o_data, wants[g]); end
    end
    i_en = 1'b0;
    repeat (LAT + 2) step();
`endif
    $display("test_gain done");
  endtask

  task automatic test_overflow();
    do_reset();
    i_div = 16'd0; i_ready = 1'b0; i_rnd = 12'hACE; i_gain = 8'd255; i_en = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k == 1) i_rnd = 12'h123;
    end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL ovf_first_valid got %b want 1", o_valid); end
    checks++; if (o_data !== FIRST_ACE) begin errors++; $display("FAIL ovf_first_data got %h want %h", o_data, FIRST_ACE); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL ovf_first_flag got %b want 0", o_ovf); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL ovf_hold_valid cyc %0d got %b want 1", k, o_valid); end
      checks++; if (o_data !== FIRST_ACE) begin errors++; $display("FAIL ovf_hold_data cyc %0d got %h want %h", k, o_data, FIRST_ACE); end
      checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag cyc %0d got %b want 1", k, o_ovf); end
    end
    i_clr_ovf = 1'b1;
    step();
    checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_clr_vs_drop got %b want 1", o_ovf); end
    i_clr_ovf = 1'b0; i_en = 1'b0;
    repeat (LAT + 1) step();
    checks++; if (o_data !== FIRST_ACE) begin errors++; $display("FAIL ovf_drain_data got %h want %h", o_data, FIRST_ACE); end
    i_clr_ovf = 1'b1;
    step();
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", o_ovf); end
    i_clr_ovf = 1'b0;
    $display("test_overflow done");
  endtask

  task automatic test_back_to_back();
    logic [11:0] vals [6];
    vals[0] = 12'h111; vals[1] = 12'h222; vals[2] = 12'h333;
    vals[3] = 12'h444; vals[4] = 12'h555; vals[5] = 12'h666;
    do_reset();
    i_div = 16'd0; i_ready = 1'b1; i_gain = 8'd255; i_en = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      if (e - 1 < 6) i_rnd = vals[e-1];
      step();
      if (e >= LAT) begin
        checks++;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid edge %0d got %b want 1", e, o_valid); end
      end
`ifndef NOISE_LPF_EN
      if (e >= 2 && e - 2 < 6) begin
        checks++;
        if (o_data !== vals[e-2]) begin errors++; $display("FAIL b2b_data edge %0d got %h want %h", e, o_data, vals[e-2]); end
      end
`endif
    end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b want 0", o_ovf); end
    i_en = 1'b0;
    repeat (LAT + 2) step();
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_div = 16'd0; i_ready = 1'b0; i_rnd = 12'hACE; i_gain = 8'd255; i_en = 1'b1;
    repeat (LAT + 3) step();
    checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL mid_pre_ovf got %b want 1", o_ovf); end
    #2;
    i_rst = 1'b0;
    i_rnd = 12'h321; i_ready = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", o_valid); end
    checks++; if (o_data !== 12'h000) begin errors++; $display("FAIL mid_data got %h want 000", o_data); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b want 0", o_ovf); end
    step();
    i_rst = 1'b1;
    for (int e = 1; e <= LAT; e++) begin
      step();
      checks++;
      if (o_valid !== (e == LAT)) begin errors++; $display("FAIL mid_release_valid edge %0d got %b want %b", e, o_valid, (e == LAT)); end
    end
`ifndef NOISE_LPF_EN
    checks++; if (o_data !== 12'h321) begin errors++; $display("FAIL mid_release_data got %h want 321", o_data); end
`endif
    i_en = 1'b0;
    repeat (LAT + 2) step();
    $display("test_reset_mid done");
  endtask

  task automatic test_lpf();
`ifdef NOISE_LPF_EN
    logic [11:0] wants [4];
    logic [11:0] prev;
    wants[0] = 12'd1023; wants[1] = 12'd1791; wants[2] = 12'd2367; wants[3] = 12'd2799;
    do_reset();
    i_div = 16'd0; i_ready = 1'b1; i_rnd = 12'hFFF; i_gain = 8'd255; i_en = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      step();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL lpf_early_valid edge %0d got %b want 0", e, o_valid); end
    end
    for (int e = 0; e < 4; e++) begin
      step();
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL lpf_valid step %0d got %b want 1", e, o_valid); end
      checks++; if (o_data !== wants[e]) begin errors++; $display("FAIL lpf_data step %0d got %0d want %0d", e, o_data, wants[e]); end
    end
    prev = wants[3];
    for (int e = 0; e < 20; e++) begin
      step();
      checks++;
      if (o_data < prev) begin errors++; $display("FAIL lpf_monotonic step %0d got %0d want >= %0d", e, o_data, prev); end
      prev = o_data;
    end
    checks++; if (o_data < 12'hF00) begin errors++; $display("FAIL lpf_settle got %h want >= f00", o_data); end
    i_en = 1'b0;
    repeat (LAT + 2) step();
`endif
    $display("test_lpf done");
  endtask

  initial begin
    test_reset();
    test_rate();
    test_gain();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_lpf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noise_sample_shaper.md
NOISE_SAMPLE_SHAPER -- requirements
Module: noise_sample_shaper

Interface
REQ-001 SHALL have parameter DW, default 12, random-sample and output width.
REQ-002 SHALL have parameter DIV_W, default 16, rate-divider width.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_rnd  input  DW  free-running random word from the upstream 12-bit LFSR, new value every cycle.
REQ-006 SHALL have port i_en  input  1  enable sampling.
REQ-007 SHALL have port i_div  input  DIV_W  sample period minus one, in clocks.
REQ-008 SHALL have port i_gain  input  8  amplitude; effective gain = (i_gain+1)/256.
REQ-009 SHALL have port i_ready  input  1  downstream accepts o_data.
REQ-010 SHALL have port i_clr_ovf  input  1  clears o_ovf.
REQ-011 SHALL have port o_data  output  DW  shaped noise sample.
REQ-012 SHALL have port o_valid  output  1  o_data valid.
REQ-013 SHALL have port o_ovf  output  1  sticky dropped-sample flag.

Function
REQ-014 SHALL run a divider counter 0..i_div while i_en=1, emitting one tick when count equals i_div and wrapping to 0 the same cycle; i_div=0 ticks every cycle.
REQ-015 SHALL hold the counter at 0 and emit no ticks while i_en=0; re-enable SHALL produce the first tick i_div+1 cycles later.
REQ-016 SHALL capture i_rnd on the tick cycle (stage S1), compute (S1*(i_gain+1))>>8 truncated to DW bits in stage S2, and present it with o_valid=1 the cycle after S2 (tick-to-o_valid latency 2 clocks without filter).
REQ-017 SHALL sample i_gain at the S2 cycle; a gain change affects only samples not yet through S2.
REQ-018 SHALL implement output states EMPTY (o_valid=0) and FULL (o_valid=1); EMPTY->FULL on new result; FULL->EMPTY on i_ready with no new result; FULL->FULL with o_data replaced when i_ready=1 and a new result arrive together (no bubble).
REQ-019 SHALL keep o_data stable while o_valid=1 and i_ready=0.
REQ-020 SHALL drop a new result arriving in FULL with i_ready=0, keep the old o_data, and set o_ovf.
REQ-021 SHALL clear o_ovf on i_clr_ovf=1; a simultaneous drop SHALL win (o_ovf stays 1).
REQ-022 SHALL let in-flight S1/S2 results complete and be presented after i_en falls.

Reset
REQ-023 SHALL, on i_rst=0, asynchronously clear counter, S1, S2, filter state, o_data=0, o_valid=0, o_ovf=0, state EMPTY.
REQ-024 SHALL discard in-flight samples on reset mid-operation; first tick after release follows REQ-015.

Configuration
REQ-025 SHALL, with NOISE_LPF_EN defined, insert a one-pole low-pass stage between S2 and output: y <= y + ((x - y) >>> 2), signed DW+2-bit accumulator, output y clipped to 0..2^DW-1, adding one clock latency (total 3).
REQ-026 SHALL, without NOISE_LPF_EN, contain no filter logic and have latency 2.

Structure
REQ-027 SHALL place DW, DIV_W, gain width, LPF shift (2) and output-state encoding in shared package noise_pkg.
REQ-028 SHALL implement the divider as sub-module noise_rate_div (i_clk, i_rst, i_en, i_div -> o_tick).

Verification
REQ-029 SHALL check i_div=3, i_en=1, i_ready=1 -> o_valid pulses every 4 clocks, first 2 clocks after first tick.
REQ-030 SHALL check i_rnd=12'hACE, i_gain=255 -> o_data=12'hACE; i_gain=127 -> 12'h567; i_gain=0 -> 12'h00A.
REQ-031 SHALL check i_div=0, i_ready=0 for 5 clocks -> o_data frozen at first sample, o_ovf=1; i_clr_ovf then -> o_ovf=0 only if no drop that cycle.
REQ-032 SHALL check i_rst pulsed low mid-stream -> o_valid, o_data, o_ovf 0 immediately, no stale sample after release.
REQ-033 SHALL check with NOISE_LPF_EN, constant i_rnd=12'hFFF, gain 255 -> output rises monotonically from 0 toward 12'hFFF, first valid at latency 3.
